// File: rtl/strhw_sl_arb_if.sv
// Handshake bundle between the SL arbiter, its requesters and the shared SL unit.
// The arbiter takes the slave modport; the requester/SL side takes master.
interface strhw_sl_arb_if #(
  parameter int N_REQ = 2,
  parameter int W     = 512
);
  logic [N_REQ-1:0]   req_trg;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_res;
  logic               sl_trg;
  logic [W-1:0]       sl_a;
  logic               sl_ready;
  logic [W-1:0]       sl_res;
  logic               busy;
  logic               err;

  modport slave (
    input  req_trg, req_a, sl_ready, sl_res,
    output req_ready, req_res, sl_trg, sl_a, busy, err
  );

  modport master (
    output req_trg, req_a, sl_ready, sl_res,
    input  req_ready, req_res, sl_trg, sl_a, busy, err
  );
endinterface

// File: rtl/strhw_sl_arb.sv
// Round-robin arbiter sharing one SL unit between N_REQ trg/ready requesters.
// STRHW_SL_ARB_FIXED_PRIO_EN: when defined, lowest pending index always wins.
//   state   | meaning
//   S_IDLE  | no grant outstanding; pick next pending requester
//   S_ISSUE | sl_trg pulse out; SL unit has not dropped ready yet
//   S_WAIT  | waiting for SL ready, then return result to winner
module strhw_sl_arb #(
  parameter int N_REQ = 2,
  parameter int W     = 512
) (
  input logic            clk_i,
  input logic            rst_ni,
  strhw_sl_arb_if.slave  bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [W-1:0]     opnd [N_REQ];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    pick;

  // First pending index at or after base, wrapping at N_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                            input logic [PW-1:0]    base);
    logic [PW-1:0] r;
    int            idx;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N_REQ;
      if (p[idx]) r = PW'(idx);
    end
    return r;
  endfunction

  // With ptr pinned at 0 the same search degenerates to fixed priority.
  assign pick = rr_pick(pend, ptr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      pend          <= '0;
      ptr           <= '0;
      win           <= '0;
      for (int i = 0; i < N_REQ; i++) opnd[i] <= '0;
      bus.req_ready <= '1;
      bus.req_res   <= '0;
      bus.sl_trg    <= 1'b0;
      bus.sl_a      <= '0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_trg[i]) begin
          if (!pend[i]) begin
            pend[i]          <= 1'b1;
            opnd[i]          <= bus.req_a[i*W +: W];
            bus.req_ready[i] <= 1'b0;
          end else begin
            bus.err <= 1'b1;
          end
        end
      end

      // A completing winner is still pending this cycle, so its own trigger
      // was treated as a violation above and cannot collide with the clear.
      case (state)
        S_IDLE: begin
          if (|pend) begin
            bus.sl_a   <= opnd[pick];
            bus.sl_trg <= 1'b1;
            bus.busy   <= 1'b1;
            win        <= pick;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.sl_trg <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.sl_ready) begin
            bus.req_res[win*W +: W] <= bus.sl_res;
            bus.req_ready[win]      <= 1'b1;
            pend[win]               <= 1'b0;
            bus.busy                <= 1'b0;
`ifdef STRHW_SL_ARB_FIXED_PRIO_EN
            ptr                     <= '0;
`else
            ptr                     <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
            state                   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
